clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Parametrised successor to the fixed 3-bit clock-enable divider.
- Runs on the single master clock and produces a nested set of divided clock-enable pulses, a half-period clock mask, and a configurable tapped delay line of the base enable.
- Adds a graceful pause/resume handshake for the MiSTer OSD pause and a synchronous realign input for video-sync lock.
- Feeds every downstream block that currently consumes the 5 MHz / 1H / 2H enables and their delayed copies.

Parameters:
- CNT_W, 3, divider counter width; base period = 2^CNT_W master clocks (legal: CNT_W >= 1).
- BASE_PHASE, 7, count value at which the base enable fires (legal: BASE_PHASE < 2^CNT_W).
- NUM_DLY, 5, number of delayed copies of the base enable (legal: NUM_DLY >= 1).

Ports:
- clk  in  1  master clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pause_req  in  1  level; request to halt enable generation at the next period boundary.
- sync_in  in  1  single-cycle pulse; realign the divider to count 0.
- count  out  CNT_W  current divider count.
- ce_div  out  CNT_W  divided enables; bit k is the 2^(k+1) division.
- cm_base  out  1  clock mask: count[CNT_W-1].
- ce_dly  out  NUM_DLY  bit i = ce_div[CNT_W-1] delayed by i+1 clocks.
- pause_ack  out  1  high while fully paused.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset state: count=0, state=RUN, delay line=0, pause_ack=0. Consequently ce_div=0, cm_base=0, ce_dly=0.
  - With BASE_PHASE=0, ce_div is asserted combinationally from count=0 in RUN.
- Counter: CNT_W-bit register, increments modulo 2^CNT_W each clock in RUN.
  - Priority at each edge: reset > sync_in (count <= 0) > pause hold > increment.
- ce_div[k]: combinational. Asserted iff state==RUN and count[k:0]==BASE_PHASE[k:0].
  - Nested property: every ce_div[k+1] pulse coincides with a ce_div[k] pulse.
  - ce_div[CNT_W-1] is the base enable: one pulse per period.
- cm_base: count[CNT_W-1], combinational. Not gated by state; held 0 while paused, since count is held at 0.
- Delay line: NUM_DLY-bit shift register, shifted every clock in all states.
  - Input is ce_div[CNT_W-1]; ce_dly[0] is the first stage.
  - It is never frozen, so pulses already launched always complete.
- States:
  - RUN: counter running, enables active. If pause_req=1 on the edge where count wraps from 2^CNT_W-1 to 0, go to DRAIN with count=0. A pause_req seen at any other count waits for the wrap. sync_in on the same edge still forces count=0 and state stays RUN; the pause then takes effect at the next wrap.
  - DRAIN: count held at 0; ce_div forced 0; delay line shifts. When the delay line is all zero go to PAUSED, pause_ack <= 1. If pause_req=0, go to RUN instead; this has priority over PAUSED.
  - PAUSED: count held at 0, all ce outputs 0, pause_ack=1. When pause_req=0, go to RUN and pause_ack <= 0 on that edge.
- Resume: on the edge entering RUN, count stays 0. It increments from the following edge. The first base enable appears BASE_PHASE clocks after entering RUN (for BASE_PHASE > 0).
- sync_in in DRAIN/PAUSED: ignored (count already 0).
- sync_in in RUN: the current period is truncated; any base pulse whose phase falls in the skipped counts is not produced.
- Reset mid-DRAIN or mid-PAUSED: immediate return to reset state; pending delayed pulses are discarded.
- No combinational path from pause_req or sync_in to any output.

Test Plan (defaults CNT_W=3, BASE_PHASE=7, NUM_DLY=5):
- Release reset, free-run 32 clocks: ce_div[0] at counts 1,3,5,7; ce_div[1] at 3,7; ce_div[2] only at 7, i.e. on edges 7,15,23,31. ce_dly[i] pulses exactly i+1 clocks after each ce_div[2]. cm_base high for counts 4-7.
- Raise pause_req at count 3: ce_div[2] still fires at count 7, then count wraps to 0 and state=DRAIN. ce_dly[4] pulses 5 clocks after that ce_div[2]. pause_ack rises on the edge after the delay line empties. All ce outputs stay 0 for 20 further clocks.
- Drop pause_req while PAUSED: pause_ack falls on the next edge, count=0 there. The first ce_div[2] appears 7 clocks later, and the period is 8 thereafter.
- Pulse sync_in at count 5: next count=0, no ce_div[2] in that period. The next ce_div[2] is 7 clocks after the sync edge.
- Drop pause_req during DRAIN (2 clocks after the wrap): return to RUN without ever asserting pause_ack. The remaining ce_dly pulses still complete on schedule.
- Assert reset_n=0 asynchronously mid-DRAIN with a pulse in ce_dly[1]: all outputs 0 immediately, without waiting for a clock edge. After release, behaviour is identical to the first scenario.

Source files
------------

// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Purpose:
//    Divides the master clock into a nested set of clock-enable pulses. It also
//    produces a half-period clock mask and a tapped delay line of the base
//    enable. A pause/resume handshake stops enable generation at a period
//    boundary, and a realign input restarts the divider at count 0 so that it
//    can lock to video sync.
//
// Parameters:
//    CNT_W      - divider counter width; base period = 2**CNT_W clocks (>= 1)
//    BASE_PHASE - count value at which the base enable fires (< 2**CNT_W)
//    NUM_DLY    - number of delayed copies of the base enable (>= 1)
//
// Ports:
//    clk        in   master clock, rising edge
//    reset_n    in   asynchronous active-low reset
//    pause_req  in   level; halt enable generation at the next period boundary
//    sync_in    in   single-cycle pulse; realign the divider to count 0
//    count      out  current divider count
//    ce_div     out  divided enables; bit k divides by 2**(k+1)
//    cm_base    out  clock mask, MSB of count
//    ce_dly     out  bit i = base enable delayed by i+1 clocks
//    pause_ack  out  high while fully paused
// -----------------------------------------------------------------------------
module clock_enable_gen #(
   parameter int CNT_W      = 3,
   parameter int BASE_PHASE = 7,
   parameter int NUM_DLY    = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pause_req,
   input  logic               sync_in,
   output logic [CNT_W-1:0]   count,
   output logic [CNT_W-1:0]   ce_div,
   output logic               cm_base,
   output logic [NUM_DLY-1:0] ce_dly,
   output logic               pause_ack
);

   localparam logic [CNT_W-1:0] PHASE   = CNT_W'(BASE_PHASE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [CNT_W-1:0]     count_q,     count_d;
   logic [NUM_DLY-1:0]   dly_q,       dly_d;
   logic                 pause_ack_q, pause_ack_d;

   logic                 run_w;
   logic                 ce_base_w;

   assign run_w = (state_q == ST_RUN);

   // Divided enables. Bit k compares only the low k+1 count bits against the
   // phase. As a result every slower pulse lands on a faster pulse.
   genvar gi;
   generate
      for (gi = 0; gi < CNT_W; gi++) begin : g_ce_div
         assign ce_div[gi] = run_w && (count_q[gi:0] == PHASE[gi:0]);
      end
   endgenerate

   assign ce_base_w = ce_div[CNT_W-1];

   // The delay line shifts in every state. Pulses launched before a pause
   // therefore always run to completion, which is what DRAIN waits for.
   generate
      if (NUM_DLY == 1) begin : g_dly_one
         assign dly_d = ce_base_w;
      end else begin : g_dly_many
         assign dly_d = {dly_q[NUM_DLY-2:0], ce_base_w};
      end
   endgenerate

   // Next-state logic. Within RUN, the order of checks matters:
   // sync_in > pause at wrap > increment.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pause_ack_d = pause_ack_q;

      case (state_q)
         ST_RUN: begin
            if (sync_in) begin
               // Realignment wins over a pending pause. The pause waits for
               // the next natural wrap.
               count_d = '0;
            end else if (count_q == CNT_MAX) begin
               count_d = '0;
               if (pause_req) begin
                  state_d = ST_DRAIN;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         ST_DRAIN: begin
            count_d = '0;
            if (!pause_req) begin
               // A cancelled pause resumes at once, even with pulses in flight.
               state_d = ST_RUN;
            end else if (dly_q == '0) begin
               state_d     = ST_PAUSED;
               pause_ack_d = 1'b1;
            end
         end

         ST_PAUSED: begin
            count_d = '0;
            if (!pause_req) begin
               state_d     = ST_RUN;
               pause_ack_d = 1'b0;
            end
         end

         default: begin
            state_d     = ST_RUN;
            count_d     = '0;
            pause_ack_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         count_q     <= '0;
         dly_q       <= '0;
         pause_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dly_q       <= dly_d;
         pause_ack_q <= pause_ack_d;
      end
   end

   assign count     = count_q;
   assign cm_base   = count_q[CNT_W-1];
   assign ce_dly    = dly_q;
   assign pause_ack = pause_ack_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Directed bench for clock_enable_gen at its default parameters. A behavioural
// model derives the expected outputs from the count, the operating mode and a
// history of base-enable pulses. Every output is compared against this model
// on each falling edge. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

   localparam int CNT_W      = 3;
   localparam int BASE_PHASE = 7;
   localparam int NUM_DLY    = 5;
   localparam int PERIOD     = 1 << CNT_W;

   logic               clk;
   logic               reset_n;
   logic               pause_req;
   logic               sync_in;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   ce_div;
   logic               cm_base;
   logic [NUM_DLY-1:0] ce_dly;
   logic               pause_ack;

   int checks = 0;
   int errors = 0;
   int cyc;

   clock_enable_gen #(
      .CNT_W      (CNT_W),
      .BASE_PHASE (BASE_PHASE),
      .NUM_DLY    (NUM_DLY)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pause_req (pause_req),
      .sync_in   (sync_in),
      .count     (count),
      .ce_div    (ce_div),
      .cm_base   (cm_base),
      .ce_dly    (ce_dly),
      .pause_ack (pause_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at t=%0t cyc=%0d: got %0d expected %0d", name, $time, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode values: 0 = running, 1 = draining, 2 = paused.
   int                 m_count;
   int                 m_mode;
   bit                 m_ack;
   bit [NUM_DLY-1:0]   m_hist;   // m_hist[i] = base enable i+1 clocks ago

   function automatic bit m_ce(int k, int cnt, int mode);
      int m;
      m = 1 << (k + 1);
      return (mode == 0) && ((cnt % m) == (BASE_PHASE % m));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_count <= 0;
         m_mode  <= 0;
         m_ack   <= 1'b0;
         m_hist  <= '0;
         cyc     <= 0;
      end else begin
         cyc    <= cyc + 1;
         m_hist <= {m_hist[NUM_DLY-2:0], m_ce(CNT_W-1, m_count, m_mode)};
         if (m_mode == 0) begin
            if (sync_in) begin
               m_count <= 0;
            end else begin
               m_count <= (m_count + 1) % PERIOD;
               if (m_count == PERIOD - 1 && pause_req) m_mode <= 1;
            end
         end else if (m_mode == 1) begin
            m_count <= 0;
            if (!pause_req) begin
               m_mode <= 0;
            end else if (m_hist == '0) begin
               m_mode <= 2;
               m_ack  <= 1'b1;
            end
         end else begin
            m_count <= 0;
            if (!pause_req) begin
               m_mode <= 0;
               m_ack  <= 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("count", int'(count), m_count);
      for (int k = 0; k < CNT_W; k++)
         chk($sformatf("ce_div[%0d]", k), int'(ce_div[k]), int'(m_ce(k, m_count, m_mode)));
      chk("cm_base", int'(cm_base), int'(m_count >= PERIOD / 2));
      for (int i = 0; i < NUM_DLY; i++)
         chk($sformatf("ce_dly[%0d]", i), int'(ce_dly[i]), int'(m_hist[i]));
      chk("pause_ack", int'(pause_ack), int'(m_ack));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_mcount(input int v);
      int n;
      n = 0;
      while (m_count != v && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk("wait_count_timeout", m_count, v);
   endtask

   task automatic wait_mmode(input int v);
      int n;
      n = 0;
      while (m_mode != v && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk("wait_mode_timeout", m_mode, v);
   endtask

   // Counts edges until the DUT shows a base pulse; returns -1 on timeout.
   task automatic edges_to_base(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!ce_div[CNT_W-1] && n < 40);
      if (!ce_div[CNT_W-1]) n = -1;
   endtask

   // 32 free-running clocks straight after reset release.
   task automatic free_run_pins();
      int pulses[$];
      for (int i = 1; i <= 32; i++) begin
         step();
         if (ce_div[CNT_W-1]) pulses.push_back(cyc);
         if (cyc == 1)  chk("ce_div0_at_cnt1", int'(ce_div[0]), 1);
         if (cyc == 2)  chk("ce_div0_at_cnt2", int'(ce_div[0]), 0);
         if (cyc == 3)  chk("ce_div1_at_cnt3", int'(ce_div[1]), 1);
         if (cyc == 4)  chk("cm_base_at_cnt4", int'(cm_base), 1);
         if (cyc == 8)  chk("cm_base_at_cnt0", int'(cm_base), 0);
         if (cyc == 12) chk("ce_dly4_at_12", int'(ce_dly[4]), 1);
      end
      chk("base_pulse_count", pulses.size(), 4);
      for (int j = 0; j < pulses.size() && j < 4; j++)
         chk("base_pulse_edge", pulses[j], 7 + 8 * j);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      int dly4_step;
      bit seen_ack;
      bit any_ce;

      reset_n   = 1'b0;
      pause_req = 1'b0;
      sync_in   = 1'b0;
      step();
      step();
      chk("reset_count", int'(count), 0);
      chk("reset_ce_div", int'(ce_div), 0);
      chk("reset_ce_dly", int'(ce_dly), 0);
      chk("reset_ack", int'(pause_ack), 0);
      reset_n = 1'b1;

      // Free run.
      free_run_pins();

      // Pause requested at count 3. The acknowledge comes 4 clocks later at
      // the pulse, plus 7 more clocks while the line drains.
      wait_mcount(3);
      pause_req = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!pause_ack && n < 40);
      chk("edges_to_pause_ack", n, 11);
      any_ce = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ce_div != '0 || ce_dly != '0) any_ce = 1'b1;
      end
      chk("paused_ce_quiet", int'(any_ce), 0);

      // Resume from PAUSED.
      pause_req = 1'b0;
      step();
      chk("resume_ack_low", int'(pause_ack), 0);
      chk("resume_count0", int'(count), 0);
      edges_to_base(n);
      chk("resume_first_base", n, 7);
      edges_to_base(n);
      chk("resume_period", n, 8);

      // Realign at count 5.
      wait_mcount(5);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      chk("sync_count0", int'(count), 0);
      n = 1;
      while (!ce_div[CNT_W-1] && n < 40) begin
         step();
         n++;
      end
      chk("sync_to_base", n, 8);

      // Pause cancelled during DRAIN, 2 clocks after the wrap.
      wait_mcount(3);
      pause_req = 1'b1;
      wait_mmode(1);
      step();
      pause_req = 1'b0;
      seen_ack  = 1'b0;
      dly4_step = -1;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (pause_ack) seen_ack = 1'b1;
         if (ce_dly[4] && dly4_step < 0) dly4_step = i;
      end
      chk("drain_cancel_no_ack", int'(seen_ack), 0);
      chk("drain_cancel_dly4_step", dly4_step, 3);

      // Asynchronous reset mid-DRAIN while ce_dly[1] is set.
      wait_mcount(3);
      pause_req = 1'b1;
      wait_mmode(1);
      step();
      chk("predrain_dly1", int'(ce_dly[1]), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_ce_div", int'(ce_div), 0);
      chk("async_rst_cm_base", int'(cm_base), 0);
      chk("async_rst_ce_dly", int'(ce_dly), 0);
      chk("async_rst_ack", int'(pause_ack), 0);
      pause_req = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      free_run_pins();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
